// File: rtl/fp_norm_pkg.sv
// Shared widths, bit indices and the stage-1 register layout for the
// FP32 post-add normalizer.
package fp_norm_pkg;
  localparam int MANT_W = 28;
  localparam int EXP_W  = 8;
  localparam int POS_W  = 5;

  localparam logic [POS_W-1:0] HIDDEN_IDX = 5'd26;
  localparam logic [POS_W-1:0] CARRY_IDX  = 5'd27;
  localparam logic [EXP_W-1:0] EXP_MAX    = '1;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic [POS_W-1:0]  pos;
    logic              zero;
  } norm_s1_t;
endpackage

// File: rtl/lopd_28bit.sv
// Combinational leading-one position detector: seven 4-bit leaves feeding a
// priority combiner where the highest non-empty leaf wins.
module lopd_28bit
  import fp_norm_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  output logic [POS_W-1:0]  pos,
  output logic              zero
);
  logic [6:0]      leaf_hit;
  logic [6:0][1:0] leaf_pos;

  // Returns {hit, position of the highest set bit within the nibble}.
  function automatic logic [2:0] lopd_4bit(input logic [3:0] d);
    casez (d)
      4'b1???: lopd_4bit = 3'b111;
      4'b01??: lopd_4bit = 3'b110;
      4'b001?: lopd_4bit = 3'b101;
      4'b0001: lopd_4bit = 3'b100;
      default: lopd_4bit = 3'b000;
    endcase
  endfunction

  for (genvar g = 0; g < 7; g++) begin : g_leaf
    assign {leaf_hit[g], leaf_pos[g]} = lopd_4bit(mant[4*g+3 -: 4]);
  end

  always_comb begin
    pos = '0;
    for (int i = 0; i < 7; i++) begin
      if (leaf_hit[i]) pos = {3'(i), leaf_pos[i]};
    end
  end

  assign zero = ~|leaf_hit;
endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage post-add normalizer: stage 1 finds the leading one, stage 2
// shifts the mantissa, adjusts the exponent and raises zero/denorm/overflow.
module fp_norm_pipe
  import fp_norm_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [MANT_W-1:0] i_mant,
  input  logic [EXP_W-1:0]  i_exp,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [MANT_W-1:0] o_mant,
  output logic [EXP_W-1:0]  o_exp,
  output logic              o_zero_flag,
  output logic              o_denorm,
  output logic              o_overflow
);
  localparam int XW = EXP_W + 1;

  norm_s1_t          s1_q;
  logic              s1_valid, s2_valid, s2_ready, in_fire, s1_adv;
  logic [POS_W-1:0]  lo_pos;
  logic              lo_zero;

  lopd_28bit u_lopd (
    .mant (i_mant),
    .pos  (lo_pos),
    .zero (lo_zero)
  );

  // Handshake: a stage takes new data when it is empty or its content leaves
  // this cycle; input transfers on i_valid & o_ready, output on o_valid & i_ready.
  assign s2_ready = ~s2_valid | i_ready;
  assign o_ready  = ~s1_valid | s2_ready;
  assign in_fire  = i_valid & o_ready;
  assign s1_adv   = s1_valid & s2_ready;
  assign o_valid  = s2_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_q     <= '{mant: i_mant, exp: i_exp, pos: lo_pos, zero: lo_zero};
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  logic [XW-1:0]     exp_w, exp_inc, lz_w, shift_w;
  logic [POS_W-1:0]  lz, shift;
  logic [MANT_W-1:0] n_mant;
  logic [EXP_W-1:0]  n_exp;
  logic              n_zero, n_denorm, n_overflow;

  always_comb begin
    exp_w      = {1'b0, s1_q.exp};
    exp_inc    = exp_w + 1'b1;
    lz         = HIDDEN_IDX - s1_q.pos;
    lz_w       = XW'(lz);
    shift_w    = (exp_w == '0) ? '0 : exp_w - 1'b1;
    shift      = POS_W'(shift_w);
    n_mant     = s1_q.mant;
    n_exp      = s1_q.exp;
    n_zero     = 1'b0;
    n_denorm   = 1'b0;
    n_overflow = 1'b0;
    if (s1_q.zero) begin
      n_mant = '0;
      n_exp  = '0;
      n_zero = 1'b1;
    end else if (s1_q.pos == CARRY_IDX) begin
      // Keep the bit shifted out as sticky so rounding still sees it.
      n_mant = {1'b0, s1_q.mant[MANT_W-1:1]} | {{(MANT_W-1){1'b0}}, s1_q.mant[0]};
      n_exp  = EXP_W'(exp_inc);
      if (exp_inc == {1'b0, EXP_MAX}) begin
        n_overflow = 1'b1;
        n_mant     = '0;
        n_exp      = EXP_MAX;
      end
    end else if (s1_q.pos == HIDDEN_IDX) begin
      n_mant = s1_q.mant;
    end else if (exp_w > lz_w) begin
      n_mant = s1_q.mant << lz;
      n_exp  = EXP_W'(exp_w - lz_w);
    end else begin
      // Exponent cannot absorb the full shift: shift only to the subnormal floor.
      n_mant   = s1_q.mant << shift;
      n_exp    = '0;
      n_denorm = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid    <= 1'b0;
      o_mant      <= '0;
      o_exp       <= '0;
      o_zero_flag <= 1'b0;
      o_denorm    <= 1'b0;
      o_overflow  <= 1'b0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        o_mant      <= n_mant;
        o_exp       <= n_exp;
        o_zero_flag <= n_zero;
        o_denorm    <= n_denorm;
        o_overflow  <= n_overflow;
      end
    end
  end
endmodule

// File: tb/tb_fp_norm_pipe.sv
// Randomized plus directed bench for fp_norm_pipe; an arithmetic model fills
// an expected queue at each accept and the monitor checks every transfer out.
module tb_fp_norm_pipe;
  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [27:0] i_mant = '0;
  logic [7:0]  i_exp = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [27:0] o_mant;
  logic [7:0]  o_exp;
  logic        o_zero_flag, o_denorm, o_overflow;

  logic [38:0] exp_q[$];
  logic [38:0] outs, prev_outs;
  logic        hold_prev = 1'b0;
  logic        rst_d = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  fp_norm_pipe dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_mant      (i_mant),
    .i_exp       (i_exp),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_mant      (o_mant),
    .o_exp       (o_exp),
    .o_zero_flag (o_zero_flag),
    .o_denorm    (o_denorm),
    .o_overflow  (o_overflow)
  );

  always #5 clk = ~clk;

  assign outs = {o_mant, o_exp, o_zero_flag, o_denorm, o_overflow};

  // Expected result {mant, exp, zero, denorm, overflow} from the normalization rules.
  function automatic logic [38:0] model(input logic [27:0] m, input logic [7:0] e);
    int p, lz, sh, oe;
    logic [27:0] om;
    logic zf, dn, ov;
    zf = 1'b0; dn = 1'b0; ov = 1'b0;
    om = m; oe = int'(e);
    p = -1;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    if (p < 0) begin
      om = '0; oe = 0; zf = 1'b1;
    end else if (p == 27) begin
      om = (m >> 1) | {27'd0, m[0]};
      oe = int'(e) + 1;
      if (oe == 255) begin ov = 1'b1; om = '0; end
    end else if (p < 26) begin
      lz = 26 - p;
      if (int'(e) > lz) begin
        om = m << lz; oe = int'(e) - lz;
      end else begin
        sh = (e == 0) ? 0 : int'(e) - 1;
        om = m << sh; oe = 0; dn = 1'b1;
      end
    end
    return {om, oe[7:0], zf, dn, ov};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_d)
      check("reset_state", {o_valid, o_ready, outs}, {2'b01, 39'd0});
    if (i_rst) begin
      exp_q.delete();
    end else begin
      if (hold_prev) check("hold_stable", {o_valid, outs}, {1'b1, prev_outs});
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_out: got %h expected nothing", outs);
        end else begin
          check("data", outs, exp_q.pop_front());
        end
      end
      if (i_valid && o_ready) exp_q.push_back(model(i_mant, i_exp));
    end
    hold_prev = o_valid & ~i_ready & ~i_rst;
    prev_outs = outs;
    rst_d     = i_rst;
  end

  task automatic directed(input string name, input logic [27:0] m, input logic [7:0] e,
                          input logic [38:0] req);
    @(posedge clk); #1;
    i_valid = 1'b1; i_mant = m; i_exp = e;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    check({name, "_lat1"}, o_valid, 0);
    @(negedge clk);
    check({name, "_lat2"}, o_valid, 1);
    check(name, outs, req);
  endtask

  task automatic present(input logic [27:0] m, input logic [7:0] e);
    @(posedge clk); #1;
    i_valid = 1'b1; i_mant = m; i_exp = e;
  endtask

  logic [27:0] r;
  int          cls, p;

  initial begin
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;

    check("model_carry",  model(28'h8000001, 8'd100), {28'h4000001, 8'd101, 3'b000});
    check("model_normal", model(28'h4000000, 8'd127), {28'h4000000, 8'd127, 3'b000});
    check("model_cancel", model(28'h0000100, 8'd50),  {28'h4000000, 8'd32,  3'b000});
    check("model_denorm", model(28'h0000100, 8'd10),  {28'h0020000, 8'd0,   3'b010});
    check("model_zero",   model(28'h0000000, 8'd77),  {28'h0000000, 8'd0,   3'b100});
    check("model_ovf",    model(28'h8000000, 8'd254), {28'h0000000, 8'd255, 3'b001});

    directed("carry",  28'h8000001, 8'd100, {28'h4000001, 8'd101, 3'b000});
    directed("normal", 28'h4000000, 8'd127, {28'h4000000, 8'd127, 3'b000});
    directed("cancel", 28'h0000100, 8'd50,  {28'h4000000, 8'd32,  3'b000});
    directed("denorm", 28'h0000100, 8'd10,  {28'h0020000, 8'd0,   3'b010});
    directed("zero",   28'h0000000, 8'd77,  {28'h0000000, 8'd0,   3'b100});
    directed("ovf",    28'h8000000, 8'd254, {28'h0000000, 8'd255, 3'b001});
    repeat (2) @(posedge clk);

    // Backpressure: two accepted, third stalls until downstream opens.
    @(posedge clk); #1 i_ready = 1'b0;
    present(28'h8000003, 8'd20);
    @(negedge clk) check("bp_rdy_a", o_ready, 1);
    present(28'h0001234, 8'd40);
    @(negedge clk) check("bp_rdy_b", o_ready, 1);
    present(28'h4abcdef, 8'd60);
    @(negedge clk) check("bp_rdy_c", o_ready, 0);
    repeat (3) @(posedge clk);
    #1 i_ready = 1'b1;
    @(negedge clk) check("bp_rdy_release", o_ready, 1);
    @(posedge clk); #1 i_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) check("bp_drain", exp_q.size(), 0);

    // Reset with two samples in flight: they must never come out.
    @(posedge clk); #1 i_ready = 1'b0;
    present(28'h0000fff, 8'd90);
    present(28'h9000000, 8'd30);
    @(posedge clk); #1 i_valid = 1'b0; i_rst = 1'b1;
    @(posedge clk); #1 i_rst = 1'b0; i_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk) check("rst_flush", exp_q.size(), 0);

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      r   = 28'($urandom);
      cls = $urandom_range(0, 9);
      if (cls == 0)      i_mant = '0;
      else if (cls <= 2) i_mant = 28'h8000000 | r;
      else if (cls == 3) i_mant = {2'b01, r[25:0]};
      else begin
        p = $urandom_range(0, 25);
        i_mant = (28'd1 << p) | (r & ((28'd1 << p) - 28'd1));
      end
      case ($urandom_range(0, 3))
        0:       i_exp = 8'($urandom_range(0, 30));
        1:       i_exp = 8'($urandom_range(253, 254));
        default: i_exp = 8'($urandom_range(0, 254));
      endcase
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
    end

    @(posedge clk); #1 i_valid = 1'b0; i_ready = 1'b1;
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
    @(negedge clk) check("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
